// File: rtl/seq_scan_pkg.sv
// Shared types and default sizes for the serial pattern scanner.
package seq_scan_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  localparam int DEF_PAT_W = 3;
  localparam int DEF_CNT_W = 8;

endpackage

// File: rtl/seq_match_core.sv
// Bit history, saturating fill count and pattern comparator.
module seq_match_core
  import seq_scan_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W
) (
  input  logic             clk_in,
  input  logic             reset_in,
  input  logic             shift_en_in,
  input  logic             bit_in,
  input  logic [PAT_W-1:0] pattern_in,
  input  logic             overlap_in,
  output logic             match_out
);

  localparam int FILL_W = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

  logic [PAT_W-1:0]  hist_q, hist_d, hist_shift;
  logic [FILL_W-1:0] fill_q, fill_d, fill_inc;
  logic              match;

  always_comb begin
    hist_shift = {hist_q[PAT_W-2:0], bit_in};
    fill_inc   = (fill_q == FILL_FULL) ? fill_q : fill_q + FILL_W'(1);
    match      = shift_en_in && (fill_inc == FILL_FULL) && (hist_shift == pattern_in);
    hist_d     = hist_q;
    fill_d     = fill_q;
    if (shift_en_in) begin
      hist_d = hist_shift;
      // Non-overlapping mode forces a full set of fresh bits before the next match.
      fill_d = (match && !overlap_in) ? '0 : fill_inc;
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

  assign match_out = match;

endmodule

// File: rtl/seq_scan_ctrl.sv
// Byte-to-bit serialiser feeding a pattern matcher, with match counter and sticky irq.
module seq_scan_ctrl
  import seq_scan_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk_in,
  input  logic             reset_in,
  input  logic [PAT_W-1:0] cfg_pattern_in,
  input  logic             cfg_overlap_in,
  input  logic [CNT_W-1:0] cfg_thresh_in,
  input  logic [7:0]       byte_in,
  input  logic             byte_valid_in,
  output logic             byte_ready_out,
  output logic             busy_out,
  output logic             detected_out,
  output logic [CNT_W-1:0] match_count_out,
  output logic             irq_out,
  input  logic             irq_clear_in
);

  state_t           state_q, state_d;
  logic [7:0]       byte_q, byte_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic             ovl_q, ovl_d;
  logic [2:0]       idx_q, idx_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             det_q, det_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             irq_q, irq_d;
  logic             match;
  logic             shift_en;

  assign shift_en = (state_q == ST_SHIFT);

  seq_match_core #(
    .PAT_W(PAT_W)
  ) u_core (
    .clk_in      (clk_in),
    .reset_in    (reset_in),
    .shift_en_in (shift_en),
    .bit_in      (byte_q[idx_q]),
    .pattern_in  (pat_q),
    .overlap_in  (ovl_q),
    .match_out   (match)
  );

  always_comb begin
    state_d = state_q;
    byte_d  = byte_q;
    pat_d   = pat_q;
    ovl_d   = ovl_q;
    idx_d   = idx_q;
    ready_d = ready_q;
    busy_d  = busy_q;
    det_d   = match;
    cnt_d   = cnt_q;
    irq_d   = irq_q;

    case (state_q)
      ST_IDLE: begin
        if (byte_valid_in) begin
          byte_d  = byte_in;
          pat_d   = cfg_pattern_in;
          ovl_d   = cfg_overlap_in;
          idx_d   = 3'd7;
          state_d = ST_SHIFT;
          ready_d = 1'b0;
          busy_d  = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (idx_q == 3'd0) begin
          state_d = ST_IDLE;
          ready_d = 1'b1;
          busy_d  = 1'b0;
        end else begin
          idx_d = idx_q - 3'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
    endcase

    // Clear wins over a coincident match; the detect pulse is unaffected.
    if (irq_clear_in) begin
      cnt_d = '0;
      irq_d = 1'b0;
    end else if (match) begin
      if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
      if ((cfg_thresh_in != '0) && (cnt_d == cfg_thresh_in)) irq_d = 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q <= ST_IDLE;
      byte_q  <= '0;
      pat_q   <= '0;
      ovl_q   <= 1'b0;
      idx_q   <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      det_q   <= 1'b0;
      cnt_q   <= '0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      byte_q  <= byte_d;
      pat_q   <= pat_d;
      ovl_q   <= ovl_d;
      idx_q   <= idx_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      det_q   <= det_d;
      cnt_q   <= cnt_d;
      irq_q   <= irq_d;
    end
  end

  assign byte_ready_out  = ready_q;
  assign busy_out        = busy_q;
  assign detected_out    = det_q;
  assign match_count_out = cnt_q;
  assign irq_out         = irq_q;

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Directed and randomized bench for seq_scan_ctrl against a bit-stream reference model.
module tb_seq_scan_ctrl;

  localparam int P = 3;
  localparam int C = 8;
  localparam int CMAX = (1 << C) - 1;

  logic         clk;
  logic         reset;
  logic [P-1:0] pat;
  logic         ovl;
  logic [C-1:0] thresh;
  logic [7:0]   tb_byte;
  logic         valid;
  logic         clr;
  logic         ready;
  logic         busy;
  logic         det;
  logic [C-1:0] cnt;
  logic         irq;

  int compared = 0;
  int mismatched = 0;

  // Reference model state: bits seen since the last window restart.
  bit         hq[$];
  int         bits_left = 0;
  logic [7:0] m_byte = '0;
  int         m_pat = 0;
  bit         m_ovl = 0;
  bit         m_det = 0;
  int         m_cnt = 0;
  bit         m_irq = 0;

  seq_scan_ctrl #(.PAT_W(P), .CNT_W(C)) dut (
    .clk_in          (clk),
    .reset_in        (reset),
    .cfg_pattern_in  (pat),
    .cfg_overlap_in  (ovl),
    .cfg_thresh_in   (thresh),
    .byte_in         (tb_byte),
    .byte_valid_in   (valid),
    .byte_ready_out  (ready),
    .busy_out        (busy),
    .detected_out    (det),
    .match_count_out (cnt),
    .irq_out         (irq),
    .irq_clear_in    (clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $display("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
      $error("check %s", tag);
    end
  endtask

  function automatic bit window_match();
    int v;
    if (hq.size() < P) return 1'b0;
    v = 0;
    for (int i = hq.size() - P; i < hq.size(); i++) v = (v << 1) | int'(hq[i]);
    return v == m_pat;
  endfunction

  // Advance the model with the inputs about to be sampled, clock, then compare.
  task automatic tick();
    bit m;
    m = 1'b0;
    if (reset) begin
      bits_left = 0;
      hq.delete();
      m_det = 0; m_cnt = 0; m_irq = 0;
    end else begin
      if (bits_left > 0) begin
        hq.push_back(m_byte[bits_left-1]);
        if (hq.size() > 8) void'(hq.pop_front());
        bits_left--;
        m = window_match();
        if (m && !m_ovl) hq.delete();
      end else if (valid) begin
        m_byte = tb_byte; m_pat = int'(pat); m_ovl = ovl; bits_left = 8;
      end
      m_det = m;
      if (clr) begin
        m_cnt = 0; m_irq = 0;
      end else if (m) begin
        if (m_cnt < CMAX) m_cnt++;
        if (thresh != 0 && m_cnt == int'(thresh)) m_irq = 1;
      end
    end
    @(posedge clk);
    #1;
    chk("ready", 32'(ready), 32'(bits_left == 0));
    chk("busy",  32'(busy),  32'(bits_left != 0));
    chk("det",   32'(det),   32'(m_det));
    chk("count", 32'(cnt),   32'(m_cnt));
    chk("irq",   32'(irq),   32'(m_irq));
  endtask

  task automatic send(input logic [7:0] b);
    tb_byte = b;
    valid = 1'b1;
    tick();
    valid = 1'b0;
    tb_byte = $urandom_range(0, 255);
    repeat (8) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; pat = '0; ovl = 1'b0; thresh = '0;
    tb_byte = '0; valid = 1'b0; clr = 1'b0;
    tick();
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_count", 32'(cnt), 32'd0);
    reset = 1'b0;

    // 110 overlapping over 0xDB: pulses after bits 3 and 6
    pat = 3'b110; ovl = 1'b1;
    send(8'hDB);
    chk("dbcount", 32'(cnt), 32'd2);

    do_reset();
    pat = 3'b101; ovl = 1'b1;
    send(8'hAA);
    chk("aa_ovl1", 32'(cnt), 32'd3);
    do_reset();
    pat = 3'b101; ovl = 1'b0;
    send(8'hAA);
    chk("aa_ovl0", 32'(cnt), 32'd2);

    // Match straddling a byte boundary
    do_reset();
    pat = 3'b110; ovl = 1'b1;
    send(8'h01);
    chk("span_first", 32'(cnt), 32'd0);
    send(8'h80);
    chk("span_second", 32'(cnt), 32'd1);

    // Threshold 2 and clear
    do_reset();
    pat = 3'b110; ovl = 1'b1; thresh = 8'd2;
    send(8'hDB);
    chk("thr_irq", 32'(irq), 32'd1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_irq", 32'(irq), 32'd0);
    chk("clr_count", 32'(cnt), 32'd0);

    // Clear held through matches: pulses remain, count stays zero
    clr = 1'b1;
    send(8'hDB);
    clr = 1'b0;
    chk("clr_hold_count", 32'(cnt), 32'd0);

    // Valid held continuously: next acceptance 9 cycles later
    do_reset();
    valid = 1'b1; tb_byte = 8'h5A;
    tick();
    repeat (8) tick();
    chk("held_idle", 32'(ready), 32'd1);
    tb_byte = 8'hC3;
    tick();
    chk("held_accept", 32'(busy), 32'd1);
    valid = 1'b0;
    repeat (8) tick();

    // Reset during bit 4 of a byte
    do_reset();
    pat = 3'b111; ovl = 1'b1; thresh = '0;
    tb_byte = 8'hFF; valid = 1'b1;
    tick();
    valid = 1'b0;
    repeat (4) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_ready", 32'(ready), 32'd1);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_det", 32'(det), 32'd0);
    chk("mid_rst_cnt", 32'(cnt), 32'd0);
    repeat (4) tick();

    // Saturation at the top of the counter with threshold at max
    do_reset();
    pat = 3'b000; ovl = 1'b1; thresh = 8'hFF;
    for (int i = 0; i < 34; i++) send(8'h00);
    chk("sat_count", 32'(cnt), 32'hFF);
    chk("sat_irq", 32'(irq), 32'd1);

    // Randomized traffic with config churn during shifting
    do_reset();
    for (int n = 0; n < 60; n++) begin
      repeat ($urandom_range(0, 2)) tick();
      pat = P'($urandom_range(0, 7));
      ovl = 1'($urandom_range(0, 1));
      thresh = C'($urandom_range(0, 6));
      clr = ($urandom_range(0, 9) == 0);
      tb_byte = 8'($urandom_range(0, 255));
      valid = 1'b1;
      tick();
      valid = 1'b0;
      clr = 1'b0;
      for (int k = 0; k < 8; k++) begin
        pat = P'($urandom_range(0, 7));
        ovl = 1'($urandom_range(0, 1));
        clr = ($urandom_range(0, 11) == 0);
        reset = ($urandom_range(0, 59) == 0);
        tick();
        reset = 1'b0;
        clr = 1'b0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
